uart_rx_ctrl: RTL

Single-clock controller that sequences the 16x-oversampled UART receive datapath. It generates programmable sample-tick and baud-tick enables from one system clock, and captures each completed RX byte into a small first-word-fall-through (FWFT) FIFO with a valid/ready read port. It also owns frame-error recovery: it counts errors, waits for a full frame of idle line, then issues the sampler's error-clear. It sits between the clock-enabled RX sampler and the byte consumer (CPU register block or DMA).

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_ctrl_if.sv | 12 +
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_rx_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types and constants
package uart_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ERR_WAIT = 2'd1,
        CLEAR    = 2'd2
    } rx_ctrl_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_PAYLOAD_W  = 8;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - byte read port (valid/ready) of the RX controller
interface uart_rx_ctrl_if;
    import uart_pkg::*;

    logic [UART_PAYLOAD_W-1:0] rd_data;
    logic                      rd_valid;
    logic                      rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through synchronous FIFO
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot the same cycle, so a full FIFO still accepts a push
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX tick generation, byte capture and frame-error recovery
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int IDLE_BITS  = 10
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic                      en,
    input  logic [DIV_W-1:0]          baud_div,
    input  logic                      rx_line,
    input  logic [UART_PAYLOAD_W-1:0] smp_data_rx,
    input  logic                      smp_data_valid,
    input  logic                      smp_frame_err,
    output logic                      smp_tick,
    output logic                      baud_tick,
    output logic                      smp_err_clr,
    uart_rx_ctrl_if.master            rd,
    output logic                      overrun,
    output logic [ERR_CNT_W-1:0]      err_cnt,
    input  logic                      clr_stats
);

    localparam int PH_W   = $clog2(UART_OVERSAMPLE);
    localparam int IDLE_W = $clog2(IDLE_BITS + 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [PH_W-1:0]   phase_cnt;
    logic              smp_tick_q;
    logic              baud_tick_q;
    logic              div_hit;
    logic [1:0]        rx_meta;
    logic              rx_sync;
    logic              smp_valid_d;
    logic              frame_err_d;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              err_rise;
    logic [IDLE_W-1:0] idle_cnt;
    rx_ctrl_state_t    state;
    rx_ctrl_state_t    next_state;

    // Live compare: a shrinking baud_div below div_cnt lets the counter run to its wrap
    assign div_hit = (div_cnt == baud_div);

    always_ff @(posedge clk) begin
        if (RST || !en) begin
            div_cnt     <= '0;
            phase_cnt   <= '0;
            smp_tick_q  <= 1'b0;
            baud_tick_q <= 1'b0;
        end else begin
            smp_tick_q  <= div_hit;
            baud_tick_q <= div_hit && (phase_cnt == PH_W'(UART_OVERSAMPLE - 1));
            if (div_hit) begin
                div_cnt   <= '0;
                phase_cnt <= phase_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign smp_tick  = smp_tick_q && en;
    assign baud_tick = baud_tick_q && en;

    always_ff @(posedge clk) begin
        if (RST) begin
            rx_meta     <= 2'b11;
            smp_valid_d <= 1'b0;
            frame_err_d <= 1'b0;
        end else begin
            rx_meta     <= {rx_meta[0], rx_line};
            smp_valid_d <= smp_data_valid;
            frame_err_d <= smp_frame_err;
        end
    end

    assign rx_sync  = rx_meta[1];
    assign push     = en && smp_data_valid && !smp_valid_d;
    assign pop      = rd.rd_valid && rd.rd_ready;
    assign err_rise = smp_frame_err && !frame_err_d;

    uart_sync_fifo #(
        .WIDTH (UART_PAYLOAD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .RST       (RST),
        .push      (push),
        .push_data (smp_data_rx),
        .pop       (pop),
        .pop_data  (rd.rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd.rd_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (RST || clr_stats) begin
            overrun <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) state <= RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:      if (err_rise) next_state = ERR_WAIT;
            ERR_WAIT: if (en && idle_cnt == IDLE_W'(IDLE_BITS)) next_state = CLEAR;
            CLEAR:    if (baud_tick) next_state = RUN;
            default:  next_state = RUN;
        endcase
    end

    always_comb begin
        smp_err_clr = 1'b0;
        if (state == CLEAR) smp_err_clr = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            idle_cnt <= '0;
        end else if (state == RUN && err_rise) begin
            idle_cnt <= '0;
        end else if (state == ERR_WAIT && baud_tick) begin
            idle_cnt <= rx_sync ? idle_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (RST || clr_stats) begin
            err_cnt <= '0;
        end else if (state == RUN && err_rise && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
